// File: rtl/aether_burst_mem_if.sv
// aether_burst_mem_if: command, write-beat and read-beat signals of the burst memory.
interface aether_burst_mem_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16
);
    logic [1:0]           cmd_i;
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [AddrWidth-1:0] start_addr_i;
    logic [AddrWidth-1:0] end_addr_i;
    logic [DataWidth-1:0] wr_data_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [DataWidth-1:0] rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_ready_i;
    logic                 abort_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    modport slave (
        input  cmd_i, cmd_valid_i, start_addr_i, end_addr_i, wr_data_i, wr_valid_i, rd_ready_i, abort_i,
        output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, busy_o, done_o, err_o
    );

    modport master (
        output cmd_i, cmd_valid_i, start_addr_i, end_addr_i, wr_data_i, wr_valid_i, rd_ready_i, abort_i,
        input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/aether_burst_mem.sv
// aether_burst_mem: single-port word memory with WRITE/READ/FILL address bursts and a 2-entry read buffer.
module aether_burst_mem #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16
) (
    input logic                clk_i,
    input logic                rst_ni,
    aether_burst_mem_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, FILL = 2'd3;

    logic [1:0]           state;
    logic [AddrWidth-1:0] addr, end_q;
    logic [DataWidth-1:0] pat, rdq, b0, b1;
    logic [DataWidth-1:0] mem [2**AddrWidth];
    logic [1:0]           cnt;
    logic                 infl, all_iss, done_q, err_q;
    logic                 accept, last_addr, wr_beat, pop, issue, last_pop;

    assign accept    = bus.cmd_valid_i && state == IDLE;
    assign last_addr = addr == end_q;
    assign wr_beat   = state == WRITE && bus.wr_valid_i;
    assign pop       = bus.rd_valid_o && bus.rd_ready_i;
    // a beat leaving this cycle frees its slot, which keeps one read per cycle sustained
    assign issue     = state == READ && !all_iss && (cnt + {1'b0, infl} - {1'b0, pop}) < 2'd2;
    assign last_pop  = pop && all_iss && !infl && cnt == 2'd1;

    assign bus.cmd_ready_o = state == IDLE;
    assign bus.wr_ready_o  = state == WRITE;
    assign bus.rd_valid_o  = cnt != 2'd0;
    assign bus.rd_data_o   = bus.rd_valid_o ? b0 : '0;
    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_ni && (wr_beat || state == FILL)) mem[addr] <= state == FILL ? pat : bus.wr_data_i;
        if (issue) rdq <= mem[addr];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            addr    <= '0;
            end_q   <= '0;
            pat     <= '0;
            cnt     <= '0;
            infl    <= 1'b0;
            all_iss <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            b0      <= '0;
            b1      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            b0     <= (infl && cnt - {1'b0, pop} == 2'd0) ? rdq : pop ? b1 : b0;
            b1     <= (infl && cnt - {1'b0, pop} == 2'd1) ? rdq : b1;
            cnt    <= cnt + {1'b0, infl} - {1'b0, pop};
            infl   <= issue;
            if (accept) begin
                if (bus.cmd_i != IDLE) begin
                    if (bus.end_addr_i < bus.start_addr_i) err_q <= 1'b1;
                    else begin
                        state   <= bus.cmd_i;
                        addr    <= bus.start_addr_i;
                        end_q   <= bus.end_addr_i;
                        pat     <= bus.wr_data_i;
                        all_iss <= 1'b0;
                    end
                end
            end else if (state != IDLE && bus.abort_i) begin
                state <= IDLE;
                cnt   <= '0;
                infl  <= 1'b0;
            end else if (wr_beat || state == FILL) begin
                if (last_addr) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end else addr <= addr + 1'b1;
            end else if (state == READ) begin
                // the counter parks on end_addr so the top address never wraps
                if (issue) begin
                    if (last_addr) all_iss <= 1'b1;
                    else addr <= addr + 1'b1;
                end
                if (last_pop) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aether_burst_mem.sv
// tb_aether_burst_mem: directed bursts with immediate-assertion checks against a shadow of written words.
module tb_aether_burst_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [15:0] sh [logic [15:0]];

    always #5 clk = ~clk;

    aether_burst_mem_if #(.DataWidth(16), .AddrWidth(16)) bif ();

    aether_burst_mem #(.DataWidth(16), .AddrWidth(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bif)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] c, input logic [15:0] s, input logic [15:0] e, input logic [15:0] d);
        bif.cmd_i = c;
        bif.start_addr_i = s;
        bif.end_addr_i = e;
        bif.wr_data_i = d;
        bif.cmd_valid_i = 1'b1;
        tick();
        bif.cmd_valid_i = 1'b0;
        bif.cmd_i = 2'b00;
    endtask

    task automatic write_burst(input logic [15:0] s, input logic [15:0] e, input logic [15:0] base,
                               input int gap_at, input int nbeats, input string tag);
        int n = int'(e) - int'(s) + 1;
        issue_cmd(2'b01, s, e, 16'h0);
        chk({tag, "_wr_ready"}, 32'(bif.wr_ready_o), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            if (i == gap_at) begin
                bif.wr_valid_i = 1'b0;
                tick();
            end
            bif.wr_valid_i = 1'b1;
            bif.wr_data_i = base + 16'(i);
            sh[s + 16'(i)] = base + 16'(i);
            tick();
            chk({tag, "_done"}, 32'(bif.done_o), 32'(i == n - 1));
        end
        bif.wr_valid_i = 1'b0;
        if (nbeats == n) begin
            chk({tag, "_busy_end"}, 32'(bif.busy_o), 32'd0);
            chk({tag, "_cmd_ready_end"}, 32'(bif.cmd_ready_o), 32'd1);
            tick();
            chk({tag, "_done_once"}, 32'(bif.done_o), 32'd0);
        end
    endtask

    task automatic fill_burst(input logic [15:0] s, input logic [15:0] e, input logic [15:0] p, input string tag);
        int n = int'(e) - int'(s) + 1;
        issue_cmd(2'b11, s, e, p);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 32'(bif.busy_o), 32'd1);
            chk({tag, "_no_done"}, 32'(bif.done_o), 32'd0);
            sh[s + 16'(i)] = p;
            tick();
        end
        chk({tag, "_done"}, 32'(bif.done_o), 32'd1);
        chk({tag, "_busy_end"}, 32'(bif.busy_o), 32'd0);
        tick();
        chk({tag, "_done_once"}, 32'(bif.done_o), 32'd0);
    endtask

    task automatic read_burst(input logic [15:0] s, input logic [15:0] e, input bit toggle,
                              input int abort_at, input string tag);
        int n = int'(e) - int'(s) + 1;
        int k = 0;
        int cyc = 0;
        int first = -1;
        bit stalled = 1'b0;
        bit ready;
        logic [15:0] held = '0;
        issue_cmd(2'b10, s, e, 16'h0);
        while (k < n && cyc < 200) begin
            ready = toggle ? (cyc % 2 == 0) : 1'b1;
            bif.rd_ready_i = ready;
            chk({tag, "_no_done"}, 32'(bif.done_o), 32'd0);
            if (stalled) begin
                chk({tag, "_stall_valid"}, 32'(bif.rd_valid_o), 32'd1);
                chk({tag, "_stall_data"}, 32'(bif.rd_data_o), 32'(held));
            end
            if (bif.rd_valid_o) begin
                if (first < 0) first = cyc;
                if (ready) begin
                    chk({tag, "_data"}, 32'(bif.rd_data_o), 32'(sh[s + 16'(k)]));
                    if (k == abort_at) bif.abort_i = 1'b1;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bif.rd_data_o;
                end
            end else chk({tag, "_idle_data"}, 32'(bif.rd_data_o), 32'd0);
            tick();
            cyc++;
            if (bif.abort_i) begin
                bif.abort_i = 1'b0;
                bif.rd_ready_i = 1'b0;
                chk({tag, "_abort_valid"}, 32'(bif.rd_valid_o), 32'd0);
                chk({tag, "_abort_done"}, 32'(bif.done_o), 32'd0);
                chk({tag, "_abort_cmd_ready"}, 32'(bif.cmd_ready_o), 32'd1);
                tick();
                chk({tag, "_abort_done_late"}, 32'(bif.done_o), 32'd0);
                return;
            end
        end
        bif.rd_ready_i = 1'b0;
        chk({tag, "_beats"}, 32'(k), 32'(n));
        if (!toggle) begin
            chk({tag, "_first_latency"}, 32'(first), 32'd2);
            chk({tag, "_cycles"}, 32'(cyc), 32'(n + 2));
        end
        chk({tag, "_done"}, 32'(bif.done_o), 32'd1);
        chk({tag, "_busy_end"}, 32'(bif.busy_o), 32'd0);
        chk({tag, "_valid_end"}, 32'(bif.rd_valid_o), 32'd0);
        tick();
        chk({tag, "_done_once"}, 32'(bif.done_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bif.cmd_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(bif.busy_o), 32'd0);
        chk({tag, "_done"}, 32'(bif.done_o), 32'd0);
        chk({tag, "_err"}, 32'(bif.err_o), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bif.rd_valid_o), 32'd0);
        chk({tag, "_wr_ready"}, 32'(bif.wr_ready_o), 32'd0);
        chk({tag, "_rd_data"}, 32'(bif.rd_data_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.cmd_i = 2'b00;
        bif.cmd_valid_i = 1'b0;
        bif.start_addr_i = '0;
        bif.end_addr_i = '0;
        bif.wr_data_i = '0;
        bif.wr_valid_i = 1'b0;
        bif.rd_ready_i = 1'b0;
        bif.abort_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        issue_cmd(2'b00, 16'h0010, 16'h0013, 16'h0);
        chk("nop_busy", 32'(bif.busy_o), 32'd0);
        chk("nop_done", 32'(bif.done_o), 32'd0);
        chk("nop_err", 32'(bif.err_o), 32'd0);
        chk("nop_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);

        write_burst(16'h0010, 16'h0013, 16'h00A0, 2, 4, "wr_a");
        read_burst(16'h0010, 16'h0013, 1'b0, -1, "rd_a");

        write_burst(16'h001F, 16'h001F, 16'h1111, -1, 1, "wr_lo");
        write_burst(16'h0030, 16'h0030, 16'h2222, -1, 1, "wr_hi");
        fill_burst(16'h0020, 16'h002F, 16'h5A5A, "fill");
        read_burst(16'h001F, 16'h0030, 1'b0, -1, "rd_fill");

        write_burst(16'h0040, 16'h0047, 16'h0C00, -1, 8, "wr_c");
        read_burst(16'h0040, 16'h0047, 1'b1, -1, "rd_toggle");

        write_burst(16'h0000, 16'h0000, 16'h0F0F, -1, 1, "wr_zero");
        write_burst(16'hFFFF, 16'hFFFF, 16'hBEEF, -1, 1, "wr_top");
        read_burst(16'hFFFF, 16'hFFFF, 1'b0, -1, "rd_top");
        read_burst(16'h0000, 16'h0000, 1'b0, -1, "rd_zero");

        issue_cmd(2'b01, 16'h0005, 16'h0004, 16'h0);
        chk("range_err", 32'(bif.err_o), 32'd1);
        chk("range_busy", 32'(bif.busy_o), 32'd0);
        chk("range_wr_ready", 32'(bif.wr_ready_o), 32'd0);
        tick();
        chk("range_err_once", 32'(bif.err_o), 32'd0);
        chk("range_busy_after", 32'(bif.busy_o), 32'd0);

        read_burst(16'h0040, 16'h0047, 1'b0, 2, "rd_abort");
        read_burst(16'h0043, 16'h0047, 1'b0, -1, "rd_after_abort");

        write_burst(16'h0060, 16'h0067, 16'h00C0, -1, 3, "wr_rst");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("mid_reset");
        tick();
        chk("mid_reset_done_late", 32'(bif.done_o), 32'd0);
        read_burst(16'h0060, 16'h0062, 1'b0, -1, "rd_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/aether_burst_mem.md
AETHER_BURST_MEM -- requirements
Module: aether_burst_mem

Interface
REQ-001 The block SHALL have parameter DataWidth, default 16, word width in bits.
REQ-002 The block SHALL have parameter AddrWidth, default 16; depth = 2**AddrWidth words, fully addressable.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port cmd_i, input, 2, command: 00 NOP, 01 WRITE, 10 READ, 11 FILL.
REQ-006 The block SHALL have port cmd_valid_i / cmd_ready_o, input / output, 1 each, command handshake.
REQ-007 The block SHALL have port start_addr_i / end_addr_i, input, AddrWidth each, inclusive burst range, sampled on command accept.
REQ-008 The block SHALL have port wr_data_i, input, DataWidth, write beat data; FILL pattern sampled on command accept.
REQ-009 The block SHALL have port wr_valid_i / wr_ready_o, input / output, 1 each, write beat handshake.
REQ-010 The block SHALL have port rd_data_o, output, DataWidth, read beat data.
REQ-011 The block SHALL have port rd_valid_o / rd_ready_i, output / input, 1 each, read beat handshake.
REQ-012 The block SHALL have port abort_i, input, 1, cancels the active burst.
REQ-013 The block SHALL have port busy_o, output, 1, high whenever state != IDLE.
REQ-014 The block SHALL have port done_o, output, 1, one-cycle pulse on normal burst completion.
REQ-015 The block SHALL have port err_o, output, 1, one-cycle pulse on rejected range.

Function
REQ-016 The block SHALL implement states IDLE, WRITE, READ, FILL; cmd_ready_o = (state == IDLE).
REQ-017 The block SHALL accept a command on clk edge with cmd_valid_i && cmd_ready_o; next state per cmd_i, address counter loaded with start_addr_i.
REQ-018 The block SHALL treat accepted NOP as no-op: stay IDLE, no done_o, no err_o.
REQ-019 The block SHALL, for WRITE/READ/FILL with end_addr_i < start_addr_i, stay IDLE and pulse err_o the cycle after accept; memory untouched.
REQ-020 The block SHALL, in WRITE, drive wr_ready_o = 1; each wr_valid_i beat writes mem[addr] and increments addr; wr_ready_o = 0 in all other states.
REQ-021 The block SHALL, in FILL, write the captured pattern to one address per cycle, start..end, with no handshake.
REQ-022 The block SHALL, in READ, issue one memory read per cycle only while the 2-entry output buffer plus in-flight reads < 2; memory read latency 1 cycle.
REQ-023 The block SHALL present read data in address order; rd_data_o and rd_valid_o SHALL hold stable while rd_valid_o && !rd_ready_i; no beat lost or duplicated.
REQ-024 The block SHALL achieve first rd_valid_o 2 cycles after accept edge and 1 beat/cycle sustained with rd_ready_i held high.
REQ-025 The block SHALL pulse done_o the cycle after the final write beat (WRITE), final pattern write (FILL), or final rd handshake (READ), and return to IDLE at that same edge.
REQ-026 The block SHALL keep the address counter from wrapping: the burst terminates at end_addr, including end_addr = 2**AddrWidth-1.
REQ-027 The block SHALL perform exactly one access when start_addr == end_addr.
REQ-028 The block SHALL, on abort_i in a non-IDLE state, go IDLE next edge, flush the read buffer (rd_valid_o = 0), discard pending writes, and not pulse done_o; abort_i in IDLE is ignored.
REQ-029 The block SHALL give abort_i priority over a coincident final beat: the beat completes, but done_o is not pulsed.
REQ-030 The block SHALL drive rd_data_o = 0 when rd_valid_o = 0.

Reset
REQ-031 The block SHALL, while rst_ni = 0 at an edge, set state IDLE, clear counter and read buffer, busy_o = 0, done_o = 0, err_o = 0, rd_valid_o = 0, wr_ready_o = 0, cmd_ready_o = 1 the following cycle.
REQ-032 The block SHALL treat reset mid-burst like abort (no done_o) and SHALL NOT initialise memory contents.

Verification
REQ-033 WRITE 0x10..0x13 with data A0..A3 (one idle gap on wr_valid_i), then READ 0x10..0x13 with rd_ready_i high -> A0..A3 in order, done_o once per burst.
REQ-034 FILL 0x20..0x2F with 0x5A5A, then READ 0x1F..0x30 -> 0x5A5A at 0x20..0x2F, neighbours unchanged.
REQ-035 READ 8 words with rd_ready_i toggling 1010... -> every beat stable while stalled, 8 unique beats, done_o one cycle after 8th handshake.
REQ-036 start = end = 0xFFFF WRITE then READ -> exactly one beat each, no wrap to 0x0000; start 5, end 4 -> err_o pulse, busy_o stays 0.
REQ-037 abort_i on third beat of 8-word READ -> rd_valid_o 0 next cycle, no done_o, cmd_ready_o 1; new READ afterwards returns correct data from its start_addr.
REQ-038 rst_ni low for one edge mid-WRITE -> all outputs at reset values next cycle, no done_o, previously written words readable.
